// File: rtl/texture_bilinear_filter_pkg.sv
// texture_bilinear_filter_pkg: shared widths, weight constants and coordinate-to-weight helper.
package texture_bilinear_filter_pkg;
  localparam int PIXEL_WIDTH_DEF = 32;
  localparam int SUB_PIXEL_WIDTH = 8;
  localparam int USER_WIDTH_DEF = 16;
  localparam int NUM_CH = PIXEL_WIDTH_DEF / SUB_PIXEL_WIDTH;
  localparam int COORD_WIDTH = 16;
  localparam int WEIGHT_WIDTH = 8;
  localparam int ROUND_CONST = 1 << (WEIGHT_WIDTH - 1);
  localparam int LATENCY = 4;

  // Only the top fraction bits form the weight; nearest mode forces weight 0 so texel00 passes exactly.
  function automatic logic [WEIGHT_WIDTH-1:0] weight(input logic [COORD_WIDTH-1:0] c, input logic en);
    return en ? WEIGHT_WIDTH'(c >> (COORD_WIDTH - WEIGHT_WIDTH)) : '0;
  endfunction
endpackage

// File: rtl/texture_bilinear_filter_if.sv
// texture_bilinear_filter_if: texel quad input stream and filtered texel output stream.
interface texture_bilinear_filter_if #(
  parameter int PIXEL_WIDTH = 32,
  parameter int USER_WIDTH = 16
);
  logic enableBilinear;
  logic s_valid;
  logic [USER_WIDTH-1:0] s_user;
  logic [PIXEL_WIDTH-1:0] texel00;
  logic [PIXEL_WIDTH-1:0] texel01;
  logic [PIXEL_WIDTH-1:0] texel10;
  logic [PIXEL_WIDTH-1:0] texel11;
  logic [15:0] texelSubCoordS;
  logic [15:0] texelSubCoordT;
  logic m_valid;
  logic [USER_WIDTH-1:0] m_user;
  logic [PIXEL_WIDTH-1:0] m_texel;
  modport master (
    output enableBilinear, s_valid, s_user, texel00, texel01, texel10, texel11,
           texelSubCoordS, texelSubCoordT,
    input m_valid, m_user, m_texel
  );
  modport slave (
    input enableBilinear, s_valid, s_user, texel00, texel01, texel10, texel11,
          texelSubCoordS, texelSubCoordT,
    output m_valid, m_user, m_texel
  );
endinterface

// File: rtl/texel_channel_lerp.sv
// texel_channel_lerp: registered rounded linear blend of two channel values by an 8-bit weight.
module texel_channel_lerp
  import texture_bilinear_filter_pkg::*;
#(
  parameter int W = SUB_PIXEL_WIDTH
) (
  input logic clk,
  input logic rst,
  input logic ce,
  input logic [W-1:0] a,
  input logic [W-1:0] b,
  input logic [WEIGHT_WIDTH-1:0] f,
  output logic [W-1:0] y
);
  localparam int AW = W + WEIGHT_WIDTH + 1;
  localparam logic [AW-1:0] ONE = AW'(1 << WEIGHT_WIDTH);
  logic [AW-1:0] acc;
  assign acc = AW'(a) * (ONE - AW'(f)) + AW'(b) * AW'(f) + AW'(ROUND_CONST);
  always_ff @(posedge clk)
    if (rst) y <= '0;
    else if (ce) y <= W'(acc >> WEIGHT_WIDTH);
endmodule

// File: rtl/texture_bilinear_filter.sv
// texture_bilinear_filter: 4-stage ce-stallable bilinear (or nearest) RGBA texel filter.
module texture_bilinear_filter
  import texture_bilinear_filter_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int SUB_PIXEL_WIDTH = texture_bilinear_filter_pkg::SUB_PIXEL_WIDTH,
  parameter int USER_WIDTH = USER_WIDTH_DEF
) (
  input logic aclk,
  input logic reset,
  input logic ce,
  texture_bilinear_filter_if.slave bus
);
  localparam int N = PIXEL_WIDTH / SUB_PIXEL_WIDTH;
  localparam int W = SUB_PIXEL_WIDTH;
  logic [PIXEL_WIDTH-1:0] t00, t01, t10, t11, top, bot, mix;
  logic [WEIGHT_WIDTH-1:0] fs1, ft1, ft2;
  logic [USER_WIDTH-1:0] u1, u2, u3;
  logic v1, v2, v3;
  always_ff @(posedge aclk)
    if (reset) begin
      {t00, t01, t10, t11} <= '0;
      {fs1, ft1, ft2} <= '0;
      {u1, u2, u3} <= '0;
      {v1, v2, v3} <= '0;
      bus.m_valid <= 1'b0;
      bus.m_user <= '0;
      bus.m_texel <= '0;
    end else if (ce) begin
      t00 <= bus.texel00;
      t01 <= bus.texel01;
      t10 <= bus.texel10;
      t11 <= bus.texel11;
      fs1 <= weight(bus.texelSubCoordS, bus.enableBilinear);
      ft1 <= weight(bus.texelSubCoordT, bus.enableBilinear);
      u1 <= bus.s_user;
      v1 <= bus.s_valid;
      ft2 <= ft1;
      u2 <= u1;
      v2 <= v1;
      u3 <= u2;
      v3 <= v2;
      bus.m_texel <= mix;
      bus.m_user <= u3;
      bus.m_valid <= v3;
    end
  // Stage 2 blends along S on both rows, stage 3 blends the two rows along T.
  for (genvar i = 0; i < N; i++) begin : g_ch
    texel_channel_lerp #(.W(W)) u_top (
      .clk(aclk), .rst(reset), .ce(ce),
      .a(t00[i*W +: W]), .b(t01[i*W +: W]), .f(fs1), .y(top[i*W +: W])
    );
    texel_channel_lerp #(.W(W)) u_bot (
      .clk(aclk), .rst(reset), .ce(ce),
      .a(t10[i*W +: W]), .b(t11[i*W +: W]), .f(fs1), .y(bot[i*W +: W])
    );
    texel_channel_lerp #(.W(W)) u_mix (
      .clk(aclk), .rst(reset), .ce(ce),
      .a(top[i*W +: W]), .b(bot[i*W +: W]), .f(ft2), .y(mix[i*W +: W])
    );
  end
endmodule
